// File: rtl/mem_forward_unit.sv
// rtl/mem_forward_unit.sv - memory-stage data memory plus operand forwarding/hazard unit
//
// Purpose:
//   Word-addressed data memory (write at the clock edge, combinational read) and a
//   two-operand forwarding unit.  The forwarding unit replaces stale register-file
//   operands with later-stage results, or flags a stall when the producing stage
//   has not produced its result yet.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   pc                    trace only, no functional effect
//   rs1_id/rs2_id         source register numbers
//   rs1_data/rs2_data     register-file operand values
//   stall_count           number of nearest stage entries to skip (bubbles)
//   st_reg_id/st_ready/st_data  packed per-stage destination, ready flag, result
//   fwd1_data/fwd2_data   resolved operands
//   stall1/stall2/stall   per-operand and combined stall requests
//   dm_addr/dm_we/dm_wdata/dm_rdata  data memory access (byte address, word aligned)

module mem_forward_unit #(
    parameter int DEPTH   = 1024,
    parameter int NSTAGES = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [31:0]            pc,
    input  logic [4:0]             rs1_id,
    input  logic [4:0]             rs2_id,
    input  logic [31:0]            rs1_data,
    input  logic [31:0]            rs2_data,
    input  logic [1:0]             stall_count,
    input  logic [5*NSTAGES-1:0]   st_reg_id,
    input  logic [NSTAGES-1:0]     st_ready,
    input  logic [32*NSTAGES-1:0]  st_data,
    output logic [31:0]            fwd1_data,
    output logic [31:0]            fwd2_data,
    output logic                   stall1,
    output logic                   stall2,
    output logic                   stall,
    input  logic [31:0]            dm_addr,
    input  logic                   dm_we,
    input  logic [31:0]            dm_wdata,
    output logic [31:0]            dm_rdata
);

    localparam int AW = $clog2(DEPTH);

    // ------------------------------------------------------------------
    // Data memory
    // ------------------------------------------------------------------
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] dm_idx;
    logic          wr_en_d;
    logic [31:0]   wr_data_d;

    // Byte offset and upper bits are dropped, so addresses wrap modulo DEPTH*4.
    assign dm_idx = dm_addr[AW+1:2];

    always_comb begin
        wr_en_d   = dm_we;
        wr_data_d = dm_wdata;
    end

    // While reset is held low every clock edge re-enters the clear branch, so
    // the array stays at zero and writes are dropped.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (wr_en_d) begin
            mem_q[dm_idx] <= wr_data_d;
        end
    end

    // Read-before-write: the old word is visible until the write edge.
    assign dm_rdata = mem_q[dm_idx];

    // ------------------------------------------------------------------
    // Forwarding
    // ------------------------------------------------------------------
    // Returns {stall, operand}.  The nearest non-skipped stage writing the
    // register wins; if that stage is not ready the operand falls back to the
    // register-file value so the output never carries stale stage data or X.
    function automatic logic [32:0] resolve(
        input logic [4:0]            id,
        input logic [31:0]           rf_val,
        input logic [1:0]            skip,
        input logic [5*NSTAGES-1:0]  ids,
        input logic [NSTAGES-1:0]    rdy,
        input logic [32*NSTAGES-1:0] dat
    );
        logic        found;
        logic [32:0] res;
        found = 1'b0;
        res   = {1'b0, rf_val};
        if (id == 5'd0) begin
            res = 33'd0;
        end else begin
            for (int i = 0; i < NSTAGES; i++) begin
                // id is non-zero here, so an equal stage id is never r0.
                if (!found && (i >= int'(skip)) && (ids[5*i +: 5] == id)) begin
                    found = 1'b1;
                    res   = rdy[i] ? {1'b0, dat[32*i +: 32]} : {1'b1, rf_val};
                end
            end
        end
        return res;
    endfunction

    always_comb begin
        {stall1, fwd1_data} = resolve(rs1_id, rs1_data, stall_count,
                                      st_reg_id, st_ready, st_data);
    end

    always_comb begin
        {stall2, fwd2_data} = resolve(rs2_id, rs2_data, stall_count,
                                      st_reg_id, st_ready, st_data);
    end

    assign stall = stall1 | stall2;

    // pc is carried for tracing only; the dropped address bits are intentional.
    logic unused_bits;
    assign unused_bits = ^{pc, dm_addr[31:AW+2], dm_addr[1:0]};

endmodule

// File: tb/tb_mem_forward_unit.sv
// tb/tb_mem_forward_unit.sv - self-checking bench for mem_forward_unit

module tb_mem_forward_unit;

    localparam int DEPTH   = 1024;
    localparam int NSTAGES = 3;

    logic                  clock;
    logic                  reset;
    logic [31:0]           pc;
    logic [4:0]            rs1_id, rs2_id;
    logic [31:0]           rs1_data, rs2_data;
    logic [1:0]            stall_count;
    logic [5*NSTAGES-1:0]  st_reg_id;
    logic [NSTAGES-1:0]    st_ready;
    logic [32*NSTAGES-1:0] st_data;
    logic [31:0]           fwd1_data, fwd2_data;
    logic                  stall1, stall2, stall;
    logic [31:0]           dm_addr;
    logic                  dm_we;
    logic [31:0]           dm_wdata;
    logic [31:0]           dm_rdata;

    int n_cmp = 0;
    int n_bad = 0;
    bit check_en = 0;

    bit [31:0] model_mem [DEPTH];

    mem_forward_unit #(.DEPTH(DEPTH), .NSTAGES(NSTAGES)) dut (
        .clock(clock), .reset(reset), .pc(pc),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .stall_count(stall_count),
        .st_reg_id(st_reg_id), .st_ready(st_ready), .st_data(st_data),
        .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
        .stall1(stall1), .stall2(stall2), .stall(stall),
        .dm_addr(dm_addr), .dm_we(dm_we), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    always @(negedge reset) begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
    end

    always @(posedge clock) begin
        if (reset === 1'b1 && dm_we === 1'b1)
            model_mem[(dm_addr >> 2) % DEPTH] = dm_wdata;
    end

    // Walk from the farthest stage toward the nearest, letting each eligible
    // match overwrite the previous decision: the last one kept is the nearest.
    task automatic model_fwd(input logic [4:0] id, input logic [31:0] rf,
                             output logic [31:0] f, output logic s);
        f = rf;
        s = 1'b0;
        if (id == 0) begin
            f = 32'd0;
        end else begin
            for (int i = NSTAGES - 1; i >= 0; i--) begin
                if (i >= stall_count && st_reg_id[5*i +: 5] == id) begin
                    if (st_ready[i]) begin
                        f = st_data[32*i +: 32];
                        s = 1'b0;
                    end else begin
                        f = rf;
                        s = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        logic [31:0] f1, f2, rd;
        logic        s1, s2;
        if (check_en) begin
            model_fwd(rs1_id, rs1_data, f1, s1);
            model_fwd(rs2_id, rs2_data, f2, s2);
            rd = model_mem[(dm_addr >> 2) % DEPTH];
            cmp("cyc_fwd1",   fwd1_data, f1);
            cmp("cyc_fwd2",   fwd2_data, f2);
            cmp("cyc_stall1", {31'd0, stall1}, {31'd0, s1});
            cmp("cyc_stall2", {31'd0, stall2}, {31'd0, s2});
            cmp("cyc_stall",  {31'd0, stall},  {31'd0, s1 | s2});
            cmp("cyc_rdata",  dm_rdata, rd);
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    initial begin
        pc = 32'h100; rs1_id = 0; rs2_id = 0; rs1_data = 0; rs2_data = 0;
        stall_count = 0; st_reg_id = 0; st_ready = '1; st_data = 0;
        dm_addr = 0; dm_we = 0; dm_wdata = 0;
        reset = 1'b1;
        #1 reset = 1'b0;
        check_en = 1;
        step(); step();
        reset = 1'b1;

        // reset then read
        step(); dm_addr = 32'h40;  #1 cmp("rst_rd_40",  dm_rdata, 32'h0);
        step(); dm_addr = 32'h7FC; #1 cmp("rst_rd_7fc", dm_rdata, 32'h0);

        // store/load, alignment and wrap
        step(); dm_addr = 32'h10; dm_wdata = 32'hDEADBEEF; dm_we = 1;
        #1 cmp("st_same_cycle", dm_rdata, 32'h0);
        step(); dm_we = 0; #1 cmp("ld_10", dm_rdata, 32'hDEADBEEF);
        step(); dm_addr = 32'h13;   #1 cmp("ld_13",   dm_rdata, 32'hDEADBEEF);
        step(); dm_addr = 32'h1010; #1 cmp("ld_1010", dm_rdata, 32'hDEADBEEF);
        step(); dm_addr = 32'h10; dm_wdata = 32'h12345678;
        step(); #1 cmp("we0_nochange", dm_rdata, 32'hDEADBEEF);

        // priority forwarding
        step(); rs1_id = 5; rs1_data = 32'hAAAA;
        st_reg_id = {5'd5, 5'd5, 5'd5}; st_ready = 3'b111;
        st_data = {32'h33, 32'h22, 32'h11}; stall_count = 0;
        #1 cmp("prio_fwd1", fwd1_data, 32'h11);
        cmp("prio_stall1", {31'd0, stall1}, 32'd0);
        step(); stall_count = 1; #1 cmp("skip1_fwd1", fwd1_data, 32'h22);
        step(); stall_count = 3; #1 cmp("skipall_fwd1", fwd1_data, 32'hAAAA);

        // load-use stall
        step(); stall_count = 0; rs1_id = 0; rs2_id = 7; rs2_data = 32'hBBBB;
        st_reg_id = {5'd0, 5'd7, 5'd7}; st_ready = 3'b110;
        st_data = {32'h0, 32'h99, 32'h0};
        #1 cmp("lu_stall2", {31'd0, stall2}, 32'd1);
        cmp("lu_stall", {31'd0, stall}, 32'd1);
        step(); st_ready = 3'b111; st_data = {32'h0, 32'h99, 32'h55};
        #1 cmp("lu_fwd2", fwd2_data, 32'h55);
        cmp("lu_nostall", {31'd0, stall}, 32'd0);

        // no match / r0
        step(); rs1_id = 3; rs1_data = 32'hABC; rs2_id = 0; rs2_data = 32'h777;
        st_reg_id = {5'd1, 5'd2, 5'd0}; st_ready = 3'b110;
        st_data = {32'h1, 32'h2, 32'hEEEE};
        #1 cmp("nomatch_fwd1", fwd1_data, 32'hABC);
        cmp("nomatch_stall1", {31'd0, stall1}, 32'd0);
        cmp("r0_fwd2", fwd2_data, 32'h0);
        cmp("r0_stall2", {31'd0, stall2}, 32'd0);

        // async reset mid-operation
        step(); dm_addr = 32'h8; dm_wdata = 32'h1234; dm_we = 1;
        step(); dm_we = 0; #1 cmp("ld_8", dm_rdata, 32'h1234);
        step(); reset = 0; #1 cmp("async_clr_8", dm_rdata, 32'h0);
        dm_we = 1; dm_wdata = 32'hFFFF;
        step(); step(); dm_we = 0; #1 cmp("we_in_reset", dm_rdata, 32'h0);
        reset = 1;
        step(); #1 cmp("post_reset_8", dm_rdata, 32'h0);

        // mixed vectors, checked by the per-cycle model comparison
        for (int k = 0; k < 40; k++) begin
            step();
            rs1_id = 5'($urandom_range(0, 3)); rs2_id = 5'($urandom_range(0, 3));
            rs1_data = $urandom; rs2_data = $urandom;
            stall_count = 2'($urandom_range(0, 3));
            for (int i = 0; i < NSTAGES; i++) begin
                st_reg_id[5*i +: 5] = 5'($urandom_range(0, 3));
                st_data[32*i +: 32] = $urandom;
            end
            st_ready = 3'($urandom);
            dm_addr = $urandom & 32'h0000_303C;
            dm_we = 1'($urandom);
            dm_wdata = $urandom;
            pc = pc + 4;
        end
        step();
        dm_we = 0;
        step(); step();
        check_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
